// File: rtl/carry_save_adder_pkg.sv
// carry_save_adder_pkg: shared width constants for the carry-save adder
package carry_save_adder_pkg;
  localparam int WIDTH_DEFAULT = 4;
  function automatic int total_w(input int w);
    return w + 2;
  endfunction
endpackage

// File: rtl/carry_save_adder_csa_cell.sv
// csa_cell: 1-bit 3:2 compressor producing sum and majority carry
module csa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cy
);
  assign s  = a ^ b ^ c;
  assign cy = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/carry_save_adder.sv
// carry_save_adder: registered 3:2 compression followed by a registered resolving adder
module carry_save_adder
  import carry_save_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            A,
  input  logic [WIDTH-1:0]            B,
  input  logic [WIDTH-1:0]            C,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            Sum,
  output logic [WIDTH-1:0]            Carry,
  output logic                        total_valid,
  output logic [total_w(WIDTH)-1:0]   Total
);
  logic [WIDTH-1:0] s_n, cy_n;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    csa_cell u_cell (.a(A[i]), .b(B[i]), .c(C[i]), .s(s_n[i]), .cy(cy_n[i]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      Sum         <= '0;
      Carry       <= '0;
      total_valid <= 1'b0;
      Total       <= '0;
    end else begin
      out_valid   <= in_valid;
      total_valid <= out_valid;
      if (in_valid) begin
        Sum   <= s_n;
        Carry <= cy_n;
      end
      if (out_valid) Total <= {2'b00, Sum} + {1'b0, Carry, 1'b0};
    end
  end
endmodule

// File: tb/tb_carry_save_adder.sv
// tb_carry_save_adder: directed vectors, valid-gap/reset sequences and random identity checks
module tb_carry_save_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, c4 = '0, s4, cy4;
  logic [5:0] t4;
  logic ov4, tv4;
  logic [15:0] a16 = '0, b16 = '0, c16 = '0, s16, cy16;
  logic [17:0] t16;
  logic ov16, tv16;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  carry_save_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a4), .B(b4), .C(c4),
    .out_valid(ov4), .Sum(s4), .Carry(cy4), .total_valid(tv4), .Total(t4)
  );
  carry_save_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a16), .B(b16), .C(c16),
    .out_valid(ov16), .Sum(s16), .Carry(cy16), .total_valid(tv16), .Total(t16)
  );
  typedef struct {
    logic [3:0] a, b, c, sum, carry;
    logic [5:0] tot;
  } vec_t;
  vec_t v[4];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic zeros4(input string n);
    chk({n, " out_valid"}, 64'(ov4), 64'd0);
    chk({n, " total_valid"}, 64'(tv4), 64'd0);
    chk({n, " Sum"}, 64'(s4), 64'd0);
    chk({n, " Carry"}, 64'(cy4), 64'd0);
    chk({n, " Total"}, 64'(t4), 64'd0);
  endtask
  initial begin
    logic [3:0] ps, pc;
    logic [17:0] prev_t16;
    logic [5:0] prev_t4;
    v[0] = '{4'b0001, 4'b0010, 4'b0011, 4'b0000, 4'b0011, 6'd6};
    v[1] = '{4'b1010, 4'b0101, 4'b0011, 4'b1100, 4'b0011, 6'd18};
    v[2] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd45};
    v[3] = '{4'b1001, 4'b0110, 4'b0010, 4'b1101, 4'b0010, 6'd17};
    // reset overrides in_valid with random operands present
    rst = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom);
      tick();
    end
    zeros4("reset");
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    zeros4("post-reset idle1");
    tick();
    zeros4("post-reset idle2");
    // back-to-back directed vectors
    for (int i = 0; i < 4; i++) begin
      a4 = v[i].a; b4 = v[i].b; c4 = v[i].c;
      in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d out_valid", i), 64'(ov4), 64'd1);
      chk($sformatf("vec%0d Sum", i), 64'(s4), 64'(v[i].sum));
      chk($sformatf("vec%0d Carry", i), 64'(cy4), 64'(v[i].carry));
      chk($sformatf("vec%0d total_valid", i), 64'(tv4), 64'(i > 0));
      if (i > 0) chk($sformatf("vec%0d Total", i - 1), 64'(t4), 64'(v[i-1].tot));
    end
    in_valid = 1'b0;
    a4 = 4'b0111; b4 = 4'b0111; c4 = 4'b0111;
    tick();
    chk("vec3 Total", 64'(t4), 64'(v[3].tot));
    chk("drain total_valid", 64'(tv4), 64'd1);
    chk("drain out_valid", 64'(ov4), 64'd0);
    chk("drain Sum hold", 64'(s4), 64'(v[3].sum));
    tick();
    chk("drain2 total_valid", 64'(tv4), 64'd0);
    chk("drain2 Total hold", 64'(t4), 64'(v[3].tot));
    // valid, idle, valid gap pattern
    a4 = v[1].a; b4 = v[1].b; c4 = v[1].c; in_valid = 1'b1;
    tick();
    chk("gap ov c1", 64'(ov4), 64'd1);
    chk("gap tv c1", 64'(tv4), 64'd0);
    a4 = v[2].a; b4 = v[2].b; c4 = v[2].c; in_valid = 1'b0;
    tick();
    chk("gap ov c2", 64'(ov4), 64'd0);
    chk("gap tv c2", 64'(tv4), 64'd1);
    chk("gap Sum hold", 64'(s4), 64'(v[1].sum));
    chk("gap Carry hold", 64'(cy4), 64'(v[1].carry));
    chk("gap Total c2", 64'(t4), 64'(v[1].tot));
    a4 = v[0].a; b4 = v[0].b; c4 = v[0].c; in_valid = 1'b1;
    tick();
    chk("gap ov c3", 64'(ov4), 64'd1);
    chk("gap tv c3", 64'(tv4), 64'd0);
    chk("gap Total hold", 64'(t4), 64'(v[1].tot));
    chk("gap Sum c3", 64'(s4), 64'(v[0].sum));
    in_valid = 1'b0;
    tick();
    chk("gap ov c4", 64'(ov4), 64'd0);
    chk("gap tv c4", 64'(tv4), 64'd1);
    chk("gap Total c4", 64'(t4), 64'(v[0].tot));
    tick();
    // reset on the cycle after a valid input discards it
    a4 = v[2].a; b4 = v[2].b; c4 = v[2].c; in_valid = 1'b1;
    tick();
    chk("midrst ov", 64'(ov4), 64'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    zeros4("midrst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst tv%0d", i), 64'(tv4), 64'd0);
      chk($sformatf("midrst ov%0d", i), 64'(ov4), 64'd0);
    end
    // random streaming: identity and resolved total at both widths
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 16'($urandom);
      tick();
      chk("rnd4 Sum", 64'(s4), 64'(a4 ^ b4 ^ c4));
      chk("rnd4 identity", 64'(s4) + 2 * 64'(cy4), 64'(a4) + 64'(b4) + 64'(c4));
      chk("rnd16 Sum", 64'(s16), 64'(a16 ^ b16 ^ c16));
      chk("rnd16 identity", 64'(s16) + 2 * 64'(cy16), 64'(a16) + 64'(b16) + 64'(c16));
      if (i > 0) begin
        chk("rnd4 Total", 64'(t4), 64'(prev_t4));
        chk("rnd16 Total", 64'(t16), 64'(prev_t16));
        chk("rnd tv", 64'({tv4, tv16}), 64'd3);
      end
      prev_t4 = 6'(a4) + 6'(b4) + 6'(c4);
      prev_t16 = 18'(a16) + 18'(b16) + 18'(c16);
    end
    in_valid = 1'b0;
    tick();
    chk("rnd4 last Total", 64'(t4), 64'(prev_t4));
    chk("rnd16 last Total", 64'(t16), 64'(prev_t16));
    ps = s4;
    pc = cy4;
    tick();
    chk("rnd idle ov", 64'({ov4, ov16}), 64'd0);
    chk("rnd idle Sum hold", 64'({s4, cy4}), 64'({ps, pc}));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
